// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - assembles a byte stream into instruction words and drives the IF memory write port.
// Loading stops after a HALT_WORD is written, or when the last memory address has been written.
module instr_mem_loader #(
  parameter int                 NB_DATA    = 32,
  parameter int                 NB_BYTE    = 8,
  parameter int                 MEM_DEPTH  = 256,
  parameter int                 NB_IADDR   = $clog2(MEM_DEPTH),
  parameter logic [NB_DATA-1:0] HALT_WORD  = {NB_DATA{1'b1}},
  parameter bit                 BIG_ENDIAN = 1'b1
) (
  input  logic                clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic                i_byte_valid,
  input  logic [NB_BYTE-1:0]  i_byte,
  output logic                o_byte_ready,
  output logic                o_we_IF,
  output logic [NB_DATA-1:0]  o_instruction_data,
  output logic [NB_IADDR-1:0] o_instr_addr,
  output logic [NB_IADDR:0]   o_count,
  output logic                o_done,
  output logic                o_overflow
);

  localparam int                  NB_BEATS  = NB_DATA / NB_BYTE;
  localparam int                  NB_BCNT   = (NB_BEATS > 1) ? $clog2(NB_BEATS) : 1;
  localparam logic [NB_BCNT-1:0]  LAST_BEAT = NB_BCNT'(NB_BEATS - 1);
  localparam logic [NB_IADDR-1:0] LAST_ADDR = NB_IADDR'(MEM_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [NB_BCNT-1:0]  beat_cnt;
  logic [NB_IADDR-1:0] ptr;
  logic [NB_DATA-1:0]  asm_q;
  logic [NB_DATA-1:0]  asm_next;
  logic                beat_acc;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // i_start restarts from any state and takes priority over a beat presented in the same cycle
  always_comb begin
    state_next   = state;
    o_byte_ready = 1'b0;
    o_we_IF      = 1'b0;
    o_done       = 1'b0;
    o_overflow   = 1'b0;
    beat_acc     = 1'b0;
    case (state)
      S_IDLE: begin
        if (i_start) state_next = S_LOAD;
      end
      S_LOAD: begin
        o_byte_ready = 1'b1;
        if (i_start) begin
          state_next = S_LOAD;
        end else if (i_byte_valid) begin
          beat_acc = 1'b1;
          if (beat_cnt == LAST_BEAT) state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        o_we_IF = 1'b1;
        if (i_start)                               state_next = S_LOAD;
        else if (o_instruction_data == HALT_WORD)  state_next = S_DONE;
        else if (ptr == LAST_ADDR)                 state_next = S_ERROR;
        else                                       state_next = S_LOAD;
      end
      S_DONE: begin
        o_done = 1'b1;
        if (i_start) state_next = S_LOAD;
      end
      S_ERROR: begin
        o_overflow = 1'b1;
        if (i_start) state_next = S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // asm_q is cleared between words, so little-endian lanes can simply be OR-ed in
  always_comb begin
    if (BIG_ENDIAN) begin
      asm_next = (asm_q << NB_BYTE) | NB_DATA'(i_byte);
    end else begin
      asm_next = asm_q | (NB_DATA'(i_byte) << (NB_BYTE * int'(beat_cnt)));
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      beat_cnt           <= '0;
      ptr                <= '0;
      asm_q              <= '0;
      o_instruction_data <= '0;
      o_instr_addr       <= '0;
      o_count            <= '0;
    end else if (i_start) begin
      beat_cnt <= '0;
      ptr      <= '0;
      asm_q    <= '0;
      o_count  <= '0;
    end else begin
      if (beat_acc) begin
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt           <= '0;
          asm_q              <= '0;
          o_instruction_data <= asm_next;
          o_instr_addr       <= ptr;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
          asm_q    <= asm_next;
        end
      end
      if (state == S_WRITE) begin
        o_count <= o_count + 1'b1;
        if (state_next == S_LOAD) ptr <= ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb/tb_instr_mem_loader.sv - random and directed checks of three loader configurations against a word-level model.
// u0: big-endian depth 256, u1: little-endian depth 8, u2: big-endian depth 4; all share one input stream.
module tb_instr_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       valid;
  logic [7:0] bdata;

  logic        rdy [3];
  logic        we  [3];
  logic [31:0] data[3];
  logic        dn  [3];
  logic        ov  [3];
  logic [7:0]  a0;
  logic [8:0]  c0;
  logic [2:0]  a1;
  logic [3:0]  c1;
  logic [1:0]  a2;
  logic [2:0]  c2;

  int n_vec = 0;
  int n_err = 0;

  int          depth[3] = '{256, 8, 4};
  bit          be   [3] = '{1'b1, 1'b0, 1'b1};
  int          st   [3];
  int          nb   [3];
  int          ptr  [3];
  int          cnt  [3];
  int          e_addr[3];
  bit          wr   [3];
  logic [31:0] acc  [3];
  logic [31:0] e_data[3];

  always #5 clk = ~clk;

  instr_mem_loader u0 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_byte_valid(valid), .i_byte(bdata),
    .o_byte_ready(rdy[0]), .o_we_IF(we[0]), .o_instruction_data(data[0]), .o_instr_addr(a0),
    .o_count(c0), .o_done(dn[0]), .o_overflow(ov[0])
  );

  instr_mem_loader #(.MEM_DEPTH(8), .BIG_ENDIAN(1'b0)) u1 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_byte_valid(valid), .i_byte(bdata),
    .o_byte_ready(rdy[1]), .o_we_IF(we[1]), .o_instruction_data(data[1]), .o_instr_addr(a1),
    .o_count(c1), .o_done(dn[1]), .o_overflow(ov[1])
  );

  instr_mem_loader #(.MEM_DEPTH(4)) u2 (
    .clk(clk), .i_rst_n(rst_n), .i_start(start), .i_byte_valid(valid), .i_byte(bdata),
    .o_byte_ready(rdy[2]), .o_we_IF(we[2]), .o_instruction_data(data[2]), .o_instr_addr(a2),
    .o_count(c2), .o_done(dn[2]), .o_overflow(ov[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // st: 0 idle, 1 session active, 2 ended on halt, 3 ended on memory full
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      st[k] = 0; nb[k] = 0; ptr[k] = 0; cnt[k] = 0; e_addr[k] = 0;
      wr[k] = 1'b0; acc[k] = '0; e_data[k] = '0;
    end
  endtask

  task automatic model_step(input int k);
    if (start) begin
      st[k] = 1; wr[k] = 1'b0; nb[k] = 0; acc[k] = '0; ptr[k] = 0; cnt[k] = 0;
    end else if (wr[k]) begin
      wr[k] = 1'b0;
      cnt[k]++;
      if (e_data[k] == 32'hFFFF_FFFF)   st[k] = 2;
      else if (e_addr[k] == depth[k] - 1) st[k] = 3;
      else                              ptr[k] = e_addr[k] + 1;
    end else if (st[k] == 1 && valid) begin
      if (be[k]) acc[k] = (acc[k] << 8) | {24'd0, bdata};
      else       acc[k] = acc[k] | ({24'd0, bdata} << (8 * nb[k]));
      nb[k]++;
      if (nb[k] == 4) begin
        e_data[k] = acc[k]; e_addr[k] = ptr[k]; wr[k] = 1'b1; nb[k] = 0; acc[k] = '0;
      end
    end
  endtask

  always @(negedge rst_n) model_reset();

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      for (int k = 0; k < 3; k++) model_step(k);
    end
  end

  task automatic cmp_inst(input int k, input logic r, input logic w, input logic [31:0] d,
                          input logic [31:0] a, input logic [31:0] c, input logic f_dn, input logic f_ov);
    check($sformatf("u%0d.byte_ready", k), 32'(r), 32'(st[k] == 1 && !wr[k]));
    check($sformatf("u%0d.we_IF", k), 32'(w), 32'(wr[k]));
    check($sformatf("u%0d.instruction_data", k), d, e_data[k]);
    check($sformatf("u%0d.instr_addr", k), a, 32'(e_addr[k]));
    check($sformatf("u%0d.count", k), c, 32'(cnt[k]));
    check($sformatf("u%0d.done", k), 32'(f_dn), 32'(st[k] == 2));
    check($sformatf("u%0d.overflow", k), 32'(f_ov), 32'(st[k] == 3));
  endtask

  always @(negedge clk) begin
    cmp_inst(0, rdy[0], we[0], data[0], 32'(a0), 32'(c0), dn[0], ov[0]);
    cmp_inst(1, rdy[1], we[1], data[1], 32'(a1), 32'(c1), dn[1], ov[1]);
    cmp_inst(2, rdy[2], we[2], data[2], 32'(a2), 32'(c2), dn[2], ov[2]);
  end

  task automatic drive(input bit s, input bit v, input logic [7:0] b);
    @(negedge clk);
    start = s; valid = v; bdata = b;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, w[31-8*i -: 8]);
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0; start = 1'b0; valid = 1'b0; bdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("lit.reset_ready", 32'(rdy[0]), 32'd0);
    check("lit.reset_count", 32'(c0), 32'd0);
    check("lit.reset_data", data[0], 32'd0);
    rst_n = 1'b1;

    drive(1'b1, 1'b0, 8'h00);
    send_word(32'h2001_0014);
    drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.first_we", 32'(we[0]), 32'd1);
    check("lit.first_addr", 32'(a0), 32'd0);
    check("lit.first_data_be", data[0], 32'h2001_0014);
    check("lit.first_data_le", data[1], 32'h1400_0120);
    send_word(32'h2002_001E); drive(1'b0, 1'b0, 8'h00);
    send_word(32'h0022_1821); drive(1'b0, 1'b0, 8'h00);
    send_word(32'hFFFF_FFFF); drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.halt_addr", 32'(a0), 32'd3);
    drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.halt_done", 32'(dn[0]), 32'd1);
    check("lit.halt_count", 32'(c0), 32'd4);
    check("lit.halt_ready", 32'(rdy[0]), 32'd0);
    check("lit.halt_last_addr_done", 32'(dn[2]), 32'd1);
    check("lit.halt_last_addr_no_ovf", 32'(ov[2]), 32'd0);

    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h20); drive(1'b0, 1'b0, 8'h55); drive(1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b0, 8'h66); drive(1'b0, 1'b0, 8'h77); drive(1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b1, 8'h14); drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.gap_data_be", data[0], 32'h2001_0014);
    check("lit.gap_data_le", data[1], 32'h1400_0120);

    drive(1'b1, 1'b0, 8'h00);
    for (int w = 0; w < 5; w++) begin
      send_word(32'h0102_0304 + 32'(w) * 32'h1111_1111);
      drive(1'b0, 1'b0, 8'h00);
    end
    drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.ovf_flag", 32'(ov[2]), 32'd1);
    check("lit.ovf_count", 32'(c2), 32'd4);
    check("lit.ovf_ready", 32'(rdy[2]), 32'd0);
    check("lit.ovf_big_count", 32'(c0), 32'd5);

    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'hAA); drive(1'b0, 1'b1, 8'hBB); drive(1'b1, 1'b1, 8'hCC);
    send_word(32'h2001_0014); drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.restart_we", 32'(we[0]), 32'd1);
    check("lit.restart_addr", 32'(a0), 32'd0);
    check("lit.restart_data", data[0], 32'h2001_0014);
    drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.restart_count", 32'(c0), 32'd1);

    drive(1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, 8'h01); drive(1'b0, 1'b1, 8'h02); drive(1'b0, 1'b0, 8'h00);
    #2 rst_n = 1'b0; #1;
    check("lit.rst_mid_ready", 32'(rdy[0]), 32'd0);
    check("lit.rst_mid_data", data[0], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    send_word(32'h1234_5678); drive(1'b0, 1'b0, 8'h00); #2;
    check("lit.pre_rst_we", 32'(we[0]), 32'd1);
    rst_n = 1'b0; #1;
    check("lit.rst_write_we", 32'(we[0]), 32'd0);
    check("lit.rst_write_data", data[0], 32'd0);
    check("lit.rst_write_count", 32'(c0), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    drive(1'b1, 1'b0, 8'h00);
    send_word(32'h0022_1821); drive(1'b0, 1'b0, 8'h00); #1;
    check("lit.fresh_addr", 32'(a0), 32'd0);
    check("lit.fresh_data", data[0], 32'h0022_1821);

    for (int i = 0; i < 4000; i++) begin
      drive($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end
    drive(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
